// File: rtl/layer2_classify_if.sv
// Avalon-MM bus between the layer-2 classifier (master) and the shared SDRAM
// (slave). Byte addresses, 16-bit data, active-low read/write strobes.
//   master: drives chipselect, byteenable, read_n, write_n, address, writedata
//           and receives waitrequest, readdatavalid, readdata.
//   slave : the mirror image.
interface layer2_classify_if;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;
    logic        chipselect;
    logic [1:0]  byteenable;
    logic        read_n;
    logic        write_n;
    logic [31:0] address;
    logic [15:0] writedata;

    modport master (
        input  waitrequest, readdatavalid, readdata,
        output chipselect, byteenable, read_n, write_n, address, writedata
    );

    modport slave (
        output waitrequest, readdatavalid, readdata,
        input  chipselect, byteenable, read_n, write_n, address, writedata
    );
endinterface

// File: rtl/layer2_classify.sv
// layer2_classify: output stage after the first hidden layer.
// Once ready is seen, walks every output node: for each hidden input it reads
// the hidden sum (binarised to active when > 0) and the node's W2 weight, and
// adds the weight to the node total when the input is active. Each node total
// is written back saturated to 16 bits; the argmax over the full-width totals
// is written to RESULT_ADDR and done is raised until ready drops.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   bus          Avalon-MM master (layer2_classify_if.master)
//   ready        start level from the HPS; must drop before a new run
//   done         high only while in DONE
//   toHexLed     {16'h0, best_idx, out_cnt, 4'h0, state} debug word
// Build option: define LAYER2_L1CACHE_EN to keep the activation bits from
// node 0 in a local register so later nodes only fetch weights.
module layer2_classify #(
    parameter logic [31:0] L1_BASE     = 32'd400_000,
    parameter logic [31:0] W2_BASE     = 32'd500_000,
    parameter logic [31:0] OUT_BASE    = 32'd410_000,
    parameter logic [31:0] RESULT_ADDR = 32'd420_000,
    parameter int          N_IN        = 200,
    parameter int          N_OUT       = 10     // at most 16: indices are 4 bits
) (
    input  logic              clk,
    input  logic              reset,
    layer2_classify_if.master bus,
    input  logic              ready,
    output logic              done,
    output logic [31:0]       toHexLed
);
    localparam int                 IW       = $clog2(N_IN + 1);
    localparam logic [IW-1:0]      IN_LAST  = IW'(N_IN - 1);
    localparam logic [3:0]         OUT_LAST = 4'(N_OUT - 1);
    localparam logic signed [31:0] MOST_NEG = 32'sh8000_0000;

    typedef enum logic [3:0] {
        IDLE, RD_L1, WAIT_L1, RD_W2, WAIT_W2, ACC, WR_OUT, NEXT, WR_RES, DONE
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      in_cnt;
    logic [3:0]         out_cnt;
    logic [3:0]         best_idx;
    logic signed [15:0] w;
    logic signed [31:0] total;
    logic signed [31:0] best;
    logic [31:0]        w2_ptr;     // W2 is node-major, so one running pointer covers it
    logic               act_cur;
    logic               rd_pos;

    assign rd_pos = $signed(bus.readdata) > 16'sd0;

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)       return 16'h7FFF;
        else if (v < -32'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

`ifdef LAYER2_L1CACHE_EN
    // WAIT_L1 is only visited during node 0, so act_q is complete before node 1.
    logic [N_IN-1:0] act_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       act_q <= '0;
        else if (state == WAIT_L1 && bus.readdatavalid) act_q[in_cnt] <= rd_pos;
    end
    assign act_cur = act_q[in_cnt];
`else
    logic act;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       act <= 1'b0;
        else if (state == WAIT_L1 && bus.readdatavalid) act <= rd_pos;
    end
    assign act_cur = act;
`endif

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (ready)              state_n = RD_L1;
            RD_L1:   if (!bus.waitrequest)   state_n = WAIT_L1;
            WAIT_L1: if (bus.readdatavalid)  state_n = RD_W2;
            RD_W2:   if (!bus.waitrequest)   state_n = WAIT_W2;
            WAIT_W2: if (bus.readdatavalid)  state_n = ACC;
            ACC: begin
                if (in_cnt != IN_LAST) begin
`ifdef LAYER2_L1CACHE_EN
                    state_n = (out_cnt == 4'd0) ? RD_L1 : RD_W2;
`else
                    state_n = RD_L1;
`endif
                end else begin
                    state_n = WR_OUT;
                end
            end
            WR_OUT:  if (!bus.waitrequest)   state_n = NEXT;
            NEXT: begin
                if (out_cnt != OUT_LAST) begin
`ifdef LAYER2_L1CACHE_EN
                    state_n = RD_W2;
`else
                    state_n = RD_L1;
`endif
                end else begin
                    state_n = WR_RES;
                end
            end
            WR_RES:  if (!bus.waitrequest)   state_n = DONE;
            DONE:    if (!ready)             state_n = IDLE;
            default:                         state_n = IDLE;
        endcase
    end

    // Bus outputs are pure decode of state, so reset drops a request at once
    // and a stalled request holds by construction.
    always_comb begin
        bus.read_n    = 1'b1;
        bus.write_n   = 1'b1;
        bus.address   = '0;
        bus.writedata = '0;
        unique case (state)
            RD_L1: begin
                bus.read_n  = 1'b0;
                bus.address = L1_BASE + 32'({in_cnt, 1'b0});
            end
            RD_W2: begin
                bus.read_n  = 1'b0;
                bus.address = w2_ptr;
            end
            WR_OUT: begin
                bus.write_n   = 1'b0;
                bus.address   = OUT_BASE + 32'({out_cnt, 1'b0});
                bus.writedata = sat16(total);
            end
            WR_RES: begin
                bus.write_n   = 1'b0;
                bus.address   = RESULT_ADDR;
                bus.writedata = {12'h0, best_idx};
            end
            default: ;
        endcase
    end

    assign bus.chipselect = 1'b1;
    assign bus.byteenable = 2'b11;
    assign done           = (state == DONE);
    assign toHexLed       = {16'h0, best_idx, out_cnt, 4'h0, state};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_cnt   <= '0;
            out_cnt  <= '0;
            best_idx <= '0;
            w        <= '0;
            total    <= '0;
            best     <= MOST_NEG;
            w2_ptr   <= W2_BASE;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    in_cnt   <= '0;
                    out_cnt  <= '0;
                    best_idx <= '0;
                    total    <= '0;
                    best     <= MOST_NEG;
                    w2_ptr   <= W2_BASE;
                end
                WAIT_W2: if (bus.readdatavalid) w <= $signed(bus.readdata);
                ACC: begin
                    if (act_cur) total <= total + {{16{w[15]}}, w};
                    in_cnt <= in_cnt + 1'b1;
                    w2_ptr <= w2_ptr + 32'd2;
                end
                NEXT: begin
                    // Strict compare keeps the lower index on ties.
                    if (total > best) begin
                        best     <= total;
                        best_idx <= out_cnt;
                    end
                    total   <= '0;
                    in_cnt  <= '0;
                    out_cnt <= out_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer2_classify.sv
// Bench for layer2_classify: a table of data sets with hand-computed node
// outputs and winners, run against an SDRAM model with optional random stall
// and read latency, plus a mid-run reset sequence.
module tb_layer2_classify;
    localparam int          N_IN        = 200;
    localparam int          N_OUT       = 10;
    localparam logic [31:0] L1_BASE     = 32'd400_000;
    localparam logic [31:0] W2_BASE     = 32'd500_000;
    localparam logic [31:0] OUT_BASE    = 32'd410_000;
    localparam logic [31:0] RESULT_ADDR = 32'd420_000;
`ifdef LAYER2_L1CACHE_EN
    localparam int EXP_L1_READS = N_IN;
`else
    localparam int EXP_L1_READS = N_IN * N_OUT;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic        done;
    logic [31:0] hex;

    layer2_classify_if l2bus();

    layer2_classify dut (
        .clk(clk), .reset(reset), .bus(l2bus), .ready(ready), .done(done), .toHexLed(hex)
    );

    always #5 clk = ~clk;

    typedef logic [N_OUT-1:0][15:0] wvec_t;
    typedef struct {
        string       name;
        bit          rnd;
        logic [15:0] l1_even, l1_odd;
        wvec_t       w_even, w_odd;
        wvec_t       exp_out;
        logic [3:0]  exp_res;
    } vec_t;

    typedef struct { logic [15:0] data; int due; } rd_t;

    logic [15:0] l1_mem [N_IN];
    logic [15:0] w2_mem [N_IN*N_OUT];
    logic [15:0] out_mem [N_OUT];
    logic [15:0] res_mem;
    int  l1_reads, bad_addr = 0, stall_viol = 0;
    int  cyc = 0, last_due = 0, stall_left = 0;
    bit  fast = 1'b1;
    bit  prev_stalled = 1'b0;
    logic [49:0] prev_req, cur_req;
    rd_t rq[$];
    int  checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SDRAM model: decides waitrequest and read returns on the falling edge so
    // the DUT sees them stable at the next rising edge.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rq.delete();
            l2bus.waitrequest   = 1'b0;
            l2bus.readdatavalid = 1'b0;
            l2bus.readdata      = 16'hBEEF;
            stall_left = 0;
            prev_stalled = 1'b0;
            last_due = 0;
            l1_reads = 0;
            res_mem = 16'hDEAD;
            for (int o = 0; o < N_OUT; o++) out_mem[o] = 16'hDEAD;
        end else begin
            cyc++;
            cur_req = {l2bus.read_n, l2bus.write_n, l2bus.address, l2bus.writedata};
            if (prev_stalled && cur_req !== prev_req) stall_viol++;
            prev_stalled = 1'b0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                l2bus.readdatavalid = 1'b1;
                l2bus.readdata      = rq[0].data;
                void'(rq.pop_front());
            end else begin
                l2bus.readdatavalid = 1'b0;
                l2bus.readdata      = 16'hBEEF;
            end
            if (!l2bus.read_n || !l2bus.write_n) begin
                if (stall_left > 0) begin
                    l2bus.waitrequest = 1'b1;
                    stall_left--;
                    prev_stalled = 1'b1;
                    prev_req = cur_req;
                end else begin
                    l2bus.waitrequest = 1'b0;
                    if (!l2bus.read_n) mem_read(l2bus.address);
                    else               mem_write(l2bus.address, l2bus.writedata);
                    stall_left = fast ? 0 : int'($urandom_range(0, 3));
                end
            end else begin
                l2bus.waitrequest = 1'b0;
            end
        end
    end

    task automatic mem_read(input logic [31:0] a);
        rd_t r;
        int  idx;
        r.data = 16'h0;
        if (a[0]) bad_addr++;
        else if (a >= L1_BASE && a < L1_BASE + 2*N_IN) begin
            idx = int'((a - L1_BASE) >> 1);
            r.data = l1_mem[idx];
            l1_reads++;
        end else if (a >= W2_BASE && a < W2_BASE + 2*N_IN*N_OUT) begin
            idx = int'((a - W2_BASE) >> 1);
            r.data = w2_mem[idx];
        end else bad_addr++;
        r.due = cyc + (fast ? 1 : int'($urandom_range(1, 5)));
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        rq.push_back(r);
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [15:0] d);
        if (a >= OUT_BASE && a < OUT_BASE + 2*N_OUT && !a[0]) out_mem[int'((a - OUT_BASE) >> 1)] = d;
        else if (a == RESULT_ADDR) res_mem = d;
        else bad_addr++;
    endtask

    task automatic load(input logic [15:0] le, input logic [15:0] lo, input wvec_t we, input wvec_t wo);
        for (int i = 0; i < N_IN; i++) l1_mem[i] = (i % 2 == 1) ? lo : le;
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++) w2_mem[o*N_IN + i] = (i % 2 == 1) ? wo[o] : we[o];
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk({name, " done reached"}, {31'h0, done}, 32'h1);
    endtask

    task automatic check_results(input string name, input wvec_t exp_out, input logic [3:0] exp_res);
        for (int o = 0; o < N_OUT; o++)
            chk($sformatf("%s out[%0d]", name, o), {16'h0, out_mem[o]}, {16'h0, exp_out[o]});
        chk({name, " result"}, {16'h0, res_mem}, {28'h0, exp_res});
        chk({name, " l1 reads"}, l1_reads, EXP_L1_READS);
    endtask

    task automatic release_ready(input string name);
        repeat (4) @(negedge clk);
        chk({name, " done held"}, {31'h0, done}, 32'h1);
        chk({name, " state DONE held"}, {28'h0, hex[3:0]}, 32'd9);
        ready = 1'b0;
        @(negedge clk);
        chk({name, " done cleared"}, {31'h0, done}, 32'h0);
        chk({name, " back to IDLE"}, {28'h0, hex[3:0]}, 32'd0);
    endtask

    vec_t vecs[3];
    wvec_t ones;

    initial begin
        // Data sets: L1 even/odd values, W2 even/odd weights per node.
        vecs[0].name = "t1_node7_wins"; vecs[0].rnd = 1'b0;
        vecs[0].l1_even = 16'd1; vecs[0].l1_odd = 16'd1; vecs[0].exp_res = 4'd7;
        vecs[1].name = "t3_saturate";   vecs[1].rnd = 1'b0;
        vecs[1].l1_even = 16'd1; vecs[1].l1_odd = 16'd1; vecs[1].exp_res = 4'd3;
        for (int o = 0; o < N_OUT; o++) begin
            ones[o] = 16'd1;
            vecs[0].w_even[o]  = (o == 7) ? 16'd2 : 16'd1;
            vecs[0].exp_out[o] = (o == 7) ? 16'd400 : 16'd200;
            vecs[1].w_even[o]  = (o == 0) ? 16'h8000 : (o == 3) ? 16'h7FFF : 16'd1;
            vecs[1].exp_out[o] = (o == 0) ? 16'h8000 : (o == 3) ? 16'h7FFF : 16'd200;
        end
        vecs[0].w_odd = vecs[0].w_even;
        vecs[1].w_odd = vecs[1].w_even;
        // Only even inputs active (+3 vs -3); 100 active weights of 100*o-300.
        // Nodes 7..9 all saturate, but node 9 has the largest full total.
        vecs[2].name = "t4_random_timing"; vecs[2].rnd = 1'b1;
        vecs[2].l1_even = 16'd3; vecs[2].l1_odd = 16'hFFFD; vecs[2].exp_res = 4'd9;
        vecs[2].w_even = {16'd600, 16'd500, 16'd400, 16'd300, 16'd200,
                          16'd100, 16'd0, 16'hFF9C, 16'hFF38, 16'hFED4};
        vecs[2].w_odd  = {N_OUT{16'h7FFF}};
        vecs[2].exp_out = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7530, 16'h4E20,
                           16'h2710, 16'h0000, 16'hD8F0, 16'hB1E0, 16'h8AD0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset read_n",     {31'h0, l2bus.read_n},     32'h1);
        chk("reset write_n",    {31'h0, l2bus.write_n},    32'h1);
        chk("reset address",    l2bus.address,             32'h0);
        chk("reset writedata",  {16'h0, l2bus.writedata},  32'h0);
        chk("reset done",       {31'h0, done},             32'h0);
        chk("reset hexled",     hex,                       32'h0);
        chk("chipselect",       {31'h0, l2bus.chipselect}, 32'h1);
        chk("byteenable",       {30'h0, l2bus.byteenable}, 32'h3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle without ready", {28'h0, hex[3:0]}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            load(vecs[v].l1_even, vecs[v].l1_odd, vecs[v].w_even, vecs[v].w_odd);
            fast = !vecs[v].rnd;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            ready = 1'b1;
            wait_done(vecs[v].name);
            check_results(vecs[v].name, vecs[v].exp_out, vecs[v].exp_res);
            release_ready(vecs[v].name);
        end

        // Mid-run reset at node 4 in RD_W2, then a clean rerun (L1 = 0,-5,...).
        load(16'd0, 16'hFFFB, ones, ones);
        fast = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b1;
        begin
            int n = 0;
            while (!(hex[11:8] == 4'd4 && hex[3:0] == 4'd3) && n < 20000) begin
                @(negedge clk);
                n++;
            end
            chk("t5 reached node4 RD_W2", {31'h0, (hex[11:8] == 4'd4 && hex[3:0] == 4'd3)}, 32'h1);
        end
        reset = 1'b1;
        #1;
        chk("t5 read_n dropped", {31'h0, l2bus.read_n}, 32'h1);
        chk("t5 state IDLE",     {28'h0, hex[3:0]},     32'd0);
        chk("t5 out_cnt cleared", {28'h0, hex[11:8]},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done("t5_rerun");
        check_results("t5_rerun", '0, 4'd0);
        release_ready("t5_rerun");

        chk("requests stable while stalled", stall_viol, 0);
        chk("no stray addresses", bad_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
